img_rsz_pxl_buf: RTL

- Downstream neighbour of the resize Compute Engine: captures each resized pixel it emits and streams the resized image out in raster order.
- Inputs are resized pixels tagged with one-hot X/Y masks. They carry no backpressure, so every valid beat must be accepted or flagged.
- Storage is a two-bank (ping-pong) row buffer. A row drains on a valid/ready stream once all its columns are written.
- When the final row has drained, the block pulses RszImgComp, which returns the upstream engine to IDLE.

---
 rtl/img_rsz_pxl_buf.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/img_rsz_pxl_buf.sv
// img_rsz_pxl_buf
// Ping-pong row buffer behind the resize compute engine. Captures resized
// pixels tagged with one-hot column/row masks (no backpressure upstream),
// and streams complete rows out in raster order on a valid/ready interface.
//
// Ports:
//   Clk, Reset      - clock, synchronous active-high reset
//   CeRszPxlData    - incoming resized pixel (colour c at [c*W +: W])
//   CeRszPxlXMsk    - one-hot column of the incoming pixel
//   CeRszPxlYMsk    - one-hot row of the incoming pixel
//   CeCompVld       - incoming pixel strobe
//   RszPxlData      - outgoing pixel
//   RszPxlVld       - outgoing pixel valid
//   RszPxlRdy       - consumer ready
//   RszPxlLastCol   - outgoing beat is the last column of its row
//   RszPxlLastRow   - outgoing beat belongs to the last image row
//   RszImgComp      - one-cycle pulse after the final beat of the image
//   BufErr          - sticky: a write was dropped (bad mask, bank busy, row mismatch)
module img_rsz_pxl_buf #(
  parameter int RSZ_IMG_WIDTH_SIZE  = 16,
  parameter int RSZ_IMG_HEIGHT_SIZE = 16,
  parameter int PXL_PRIM_COLOR_NUM  = 3,
  parameter int PXL_PRIM_COLOR_W    = 8
) (
  input  logic                                           Clk,
  input  logic                                           Reset,
  input  logic [PXL_PRIM_COLOR_NUM*PXL_PRIM_COLOR_W-1:0] CeRszPxlData,
  input  logic [RSZ_IMG_WIDTH_SIZE-1:0]                  CeRszPxlXMsk,
  input  logic [RSZ_IMG_HEIGHT_SIZE-1:0]                 CeRszPxlYMsk,
  input  logic                                           CeCompVld,
  output logic [PXL_PRIM_COLOR_NUM*PXL_PRIM_COLOR_W-1:0] RszPxlData,
  output logic                                           RszPxlVld,
  input  logic                                           RszPxlRdy,
  output logic                                           RszPxlLastCol,
  output logic                                           RszPxlLastRow,
  output logic                                           RszImgComp,
  output logic                                           BufErr
);

  localparam int DW = PXL_PRIM_COLOR_NUM * PXL_PRIM_COLOR_W;
  localparam int XW = (RSZ_IMG_WIDTH_SIZE  > 1) ? $clog2(RSZ_IMG_WIDTH_SIZE)  : 1;
  localparam int RW = (RSZ_IMG_HEIGHT_SIZE > 1) ? $clog2(RSZ_IMG_HEIGHT_SIZE) : 1;
  localparam int NW = RW + 1;  // next-row counters run past the last row

  typedef enum logic [1:0] {
    BANK_FREE,
    BANK_FILL,
    BANK_FULL
  } bankState_t;

  bankState_t                    bankState [2];
  logic [RW-1:0]                 bankTag   [2];
  logic [RSZ_IMG_WIDTH_SIZE-1:0] fillMap   [2];
  logic [NW-1:0]                 nextRow   [2];
  logic [DW-1:0]                 pxlMem    [2][RSZ_IMG_WIDTH_SIZE];

  logic [RW-1:0] drainRow;
  logic [XW-1:0] drainCol;
  logic          drainBank;

  logic [XW-1:0]                 wrCol;
  logic [RW-1:0]                 wrRow;
  logic                          wrBank;
  logic                          wrMskOk;
  logic                          wrBankOk;
  logic                          wrAcc;
  logic                          wrRej;
  logic [RSZ_IMG_WIDTH_SIZE-1:0] wrNewMap;
  logic                          xfer;

  // One-hot to binary decode of the write masks.
  always_comb begin
    wrCol = '0;
    for (int unsigned i = 0; i < RSZ_IMG_WIDTH_SIZE; i++) begin
      if (CeRszPxlXMsk[i]) wrCol = XW'(i);
    end
    wrRow = '0;
    for (int unsigned i = 0; i < RSZ_IMG_HEIGHT_SIZE; i++) begin
      if (CeRszPxlYMsk[i]) wrRow = RW'(i);
    end
  end

  always_comb begin
    wrBank   = wrRow[0];
    wrMskOk  = $onehot(CeRszPxlXMsk) && $onehot(CeRszPxlYMsk);
    wrBankOk = ((bankState[wrBank] == BANK_FREE) && (nextRow[wrBank] == {1'b0, wrRow})) ||
               ((bankState[wrBank] == BANK_FILL) && (bankTag[wrBank] == wrRow));
    wrAcc    = CeCompVld && wrMskOk && wrBankOk;
    wrRej    = CeCompVld && !wrAcc;
    wrNewMap = fillMap[wrBank] | CeRszPxlXMsk;
  end

  // Stream outputs are decoded straight from registered bank state so the
  // first beat appears the cycle after the completing write.
  always_comb begin
    drainBank     = drainRow[0];
    RszPxlVld     = (bankState[drainBank] == BANK_FULL) && (bankTag[drainBank] == drainRow);
    RszPxlData    = pxlMem[drainBank][drainCol];
    RszPxlLastCol = (drainCol == XW'(RSZ_IMG_WIDTH_SIZE - 1));
    RszPxlLastRow = (drainRow == RW'(RSZ_IMG_HEIGHT_SIZE - 1));
    xfer          = RszPxlVld && RszPxlRdy;
  end

  // Pixel storage needs no reset: the fill bitmaps gate what is ever read.
  always_ff @(posedge Clk) begin
    if (wrAcc) pxlMem[wrBank][wrCol] <= CeRszPxlData;
  end

  // A draining bank is FULL and therefore rejects writes, so the write and
  // drain updates below never target the same bank in one cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned b = 0; b < 2; b++) begin
        bankState[b] <= BANK_FREE;
        bankTag[b]   <= '0;
        fillMap[b]   <= '0;
      end
      nextRow[0] <= '0;
      nextRow[1] <= NW'(1);
      drainRow   <= '0;
      drainCol   <= '0;
      RszImgComp <= 1'b0;
      BufErr     <= 1'b0;
    end else begin
      RszImgComp <= xfer && RszPxlLastCol && RszPxlLastRow;
      if (wrRej) BufErr <= 1'b1;

      if (wrAcc) begin
        fillMap[wrBank]   <= wrNewMap;
        bankTag[wrBank]   <= wrRow;
        bankState[wrBank] <= (&wrNewMap) ? BANK_FULL : BANK_FILL;
      end

      if (xfer) begin
        if (RszPxlLastCol) begin
          drainCol             <= '0;
          bankState[drainBank] <= BANK_FREE;
          fillMap[drainBank]   <= '0;
          if (RszPxlLastRow) begin
            drainRow   <= '0;
            nextRow[0] <= '0;
            nextRow[1] <= NW'(1);
          end else begin
            drainRow           <= drainRow + RW'(1);
            nextRow[drainBank] <= nextRow[drainBank] + NW'(2);
          end
        end else begin
          drainCol <= drainCol + XW'(1);
        end
      end
    end
  end

endmodule
